// File: rtl/shift_unit_pipe.sv
// shift_unit_pipe
//   Pipelined barrel shifter. Stage k applies a shift of 2^k when bit k of the
//   shift amount is set, so SHW = log2(WIDTH) register stages give a latency of
//   SHW cycles. Modes: 00 SRL, 01 SRA, 10 SLL, 11 ROR.
//   A valid/ready handshake with a per-stage ready chain lets a full stage
//   forward and reload in the same cycle, which gives full throughput and lets
//   backpressure collapse bubbles.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   input transaction present
//   in_ready   unit accepts input this cycle (combinational from out_ready)
//   in_a       operand to shift
//   in_b       shift amount, only in_b[SHW-1:0] is used
//   in_mode    shift mode
//   out_valid  result present (registered)
//   out_ready  downstream accepts result
//   out_s      shifted result (registered)

module shift_unit_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        MODE_SRL = 2'b00,
        MODE_SRA = 2'b01,
        MODE_SLL = 2'b10,
        MODE_ROR = 2'b11
    } mode_e;

    // Shift x by n positions (n is always a power of two below WIDTH).
    function automatic logic [WIDTH-1:0] stage_shift(
        input logic [WIDTH-1:0] x,
        input mode_e            mode,
        input int               n
    );
        logic [WIDTH-1:0] r;
        case (mode)
            MODE_SRL: r = x >> n;
            MODE_SRA: r = $signed(x) >>> n;
            MODE_SLL: r = x << n;
            default:  r = (x >> n) | (x << (WIDTH - n));
        endcase
        return r;
    endfunction

    logic [SHW-1:0]   v_q;
    logic [SHW-1:0]   v_d;
    logic [SHW-1:0]   rdy;
    logic [WIDTH-1:0] d_q    [SHW];
    logic [WIDTH-1:0] d_d    [SHW];
    logic [SHW-1:0]   amt_q  [SHW];
    logic [SHW-1:0]   amt_d  [SHW];
    mode_e            mode_q [SHW];
    mode_e            mode_d [SHW];

    // Upstream view of each stage: the input port for stage 0, the previous
    // stage's registers otherwise.
    logic [SHW-1:0]   up_v;
    logic [WIDTH-1:0] up_d    [SHW];
    logic [SHW-1:0]   up_amt  [SHW];
    mode_e            up_mode [SHW];

    // Amount bits above SHW-1 are intentionally ignored.
    logic unused_b_hi;
    assign unused_b_hi = ^in_b[WIDTH-1:SHW];

    always_comb begin
        up_v       = '0;
        up_v[0]    = in_valid;
        up_d[0]    = in_a;
        up_amt[0]  = in_b[SHW-1:0];
        up_mode[0] = mode_e'(in_mode);
        for (int k = 1; k < SHW; k++) begin
            up_v[k]    = v_q[k-1];
            up_d[k]    = d_q[k-1];
            up_amt[k]  = amt_q[k-1];
            up_mode[k] = mode_q[k-1];
        end
    end

    // Ready chain from the output back to the input: a stage can load when it
    // is empty or when its own content moves on this cycle.
    always_comb begin
        rdy          = '0;
        rdy[SHW-1]   = !v_q[SHW-1] || out_ready;
        for (int k = SHW - 2; k >= 0; k--) begin
            rdy[k] = !v_q[k] || rdy[k+1];
        end
    end

    always_comb begin
        v_d = v_q;
        for (int k = 0; k < SHW; k++) begin
            d_d[k]    = d_q[k];
            amt_d[k]  = amt_q[k];
            mode_d[k] = mode_q[k];
            if (rdy[k]) begin
                v_d[k] = up_v[k];
                // Data fields only move with a real transaction; a bubble
                // leaves the previous payload in place.
                if (up_v[k]) begin
                    d_d[k]    = up_amt[k][k] ? stage_shift(up_d[k], up_mode[k], 1 << k)
                                             : up_d[k];
                    amt_d[k]  = up_amt[k];
                    mode_d[k] = up_mode[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int k = 0; k < SHW; k++) begin
                d_q[k]    <= '0;
                amt_q[k]  <= '0;
                mode_q[k] <= MODE_SRL;
            end
        end else begin
            v_q <= v_d;
            for (int k = 0; k < SHW; k++) begin
                d_q[k]    <= d_d[k];
                amt_q[k]  <= amt_d[k];
                mode_q[k] <= mode_d[k];
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_q[SHW-1];
    assign out_s     = d_q[SHW-1];

endmodule

// File: doc/shift_unit_pipe.md
# shift_unit_pipe

Parametrised, pipelined barrel shifter supporting logical right, arithmetic right, logical left and rotate-right modes on a WIDTH-bit operand. It is the next-generation shift unit in the arithmetic datapath. It places one log2 shift stage per pipeline register, and uses a valid/ready handshake on both sides so it can sit between ALU operand staging and writeback with full throughput and backpressure.

## Interface
- WIDTH, 8, operand width; power of two, ≥ 2. Local SHW = log2(WIDTH) = number of stages = latency.
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  input transaction present
- in_ready  out  1  unit accepts input this cycle
- in_a  in  WIDTH  operand to shift
- in_b  in  WIDTH  shift amount; only in_b[SHW-1:0] used, upper bits ignored
- in_mode  in  2  00 SRL, 01 SRA, 10 SLL, 11 ROR
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- out_s  out  WIDTH  shifted result

## Operation
- Stage k (k = 0..SHW-1) holds: valid bit v[k], data d[k], remaining amount bits, and mode.
- Stage 0 loads f0(in_a), which applies shift 2^0 if in_b[0]. Stage k loads fk(d[k-1]), which applies shift 2^k if amount bit k.
- Per-stage shift by n = 2^k when its bit is set:
  - SRL: zero-fill top n bits.
  - SRA: fill top n bits with current MSB of d.
  - SLL: zero-fill bottom n bits.
  - ROR: bottom n bits move to the top.
- Bit clear: data passes unchanged.
- Net result:
  - SRL/SLL: a >> b or a << b, b = in_b[SHW-1:0].
  - SRA: $signed(a) >>> b.
  - ROR: rotate right by b.
- Amount b = 0 returns in_a for all modes. SRA with b = WIDTH-1 yields all copies of the sign bit.
- Handshake and stall chain:
  - rdy[SHW-1] = !v[SHW-1] || out_ready.
  - rdy[k] = !v[k] || rdy[k+1].
  - in_ready = rdy[0].
- Stage k loads when rdy[k]. v[k] takes the valid of the upstream stage (in_valid for stage 0). A bubble enters when upstream is empty.
- Stalled stage (v[k] && !rdy[k]) holds all fields unchanged.
- out_valid = v[SHW-1]; out_s = d[SHW-1].
- A transaction is accepted when in_valid && in_ready and delivered when out_valid && out_ready.
- out_s is stable while out_valid && !out_ready.
- Simultaneous events:
  - A full stage whose downstream is ready both forwards its content and accepts new content in the same cycle.
  - A full pipeline with out_ready=1 accepts one input per cycle.
- in_valid may drop without acceptance. Inputs are only sampled on acceptance.
- Order is preserved. Results never merge, duplicate or drop.

## Timing
- Reset (rst_n low, async):
  - all v[k]=0, all d[k]=0.
  - out_valid=0, out_s=0.
  - in_ready=1 combinationally once reset is applied.
- Reset mid-operation discards all in-flight transactions. No output is produced for them after rst_n rises.
- First acceptance is possible in the first clk edge with rst_n high.
- Latency: accepted at edge t means out_valid high after edge t+SHW-1 (SHW register stages). For WIDTH=8, out_valid is high in the 3rd cycle after acceptance.
- Throughput: 1 transaction per cycle with out_ready held high.
- in_ready depends combinationally on out_ready through SHW AND/OR levels. No other combinational in→out path exists: out_s and out_valid are registered.
- Capacity: SHW transactions in flight. With out_ready low, in_ready drops once all SHW stages are full.

## Test plan
- Modes, WIDTH=8, in_a=8'hB4, in_b=8'h03, out_ready=1:
  - SRL → 8'h16
  - SRA → 8'hF6
  - SLL → 8'hA0
  - ROR → 8'h96
  - Each appears exactly 3 cycles after acceptance; back-to-back inputs produce results on consecutive cycles.
- Amount edges:
  - in_b=8'hFB, SRA on 8'hB4 → 8'hF6 (upper bits ignored).
  - b=0 on 8'h5A, any mode → 8'h5A.
  - SRA on 8'h80 with b=7 → 8'hFF.
  - SRL on 8'h80 with b=7 → 8'h01.
  - ROR on 8'h01 with b=7 → 8'h02.
- Backpressure: stream values 8'h01..8'h08 (SLL by 1) with in_valid=1 and out_ready low for cycles 4–8:
  - in_ready drops after the 3rd acceptance.
  - out_s holds 8'h02 while stalled.
  - All 8 results 8'h02..8'h10 arrive in order with no loss or duplication.
- Bubbles: assert in_valid on alternate cycles with out_ready=1 → out_valid toggles identically, delayed by 3 cycles.
- Reset mid-flight:
  - Assert rst_n low asynchronously (between edges) with 3 transactions in flight → out_valid=0 and out_s=0 immediately.
  - After release, no stale result appears.
  - A new input yields its correct result at latency 3.
- Randomised WIDTH=16 and WIDTH=32 runs with random out_ready are compared against a reference model per mode.
